// File: rtl/store_data_unit_if.sv
// Store request + data-memory write port bundle for store_data_unit.
// master = environment (MEM-stage decode and data memory); slave = the store unit.
// Pure wiring: no latency or backpressure of its own.
interface store_data_unit_if #(
    parameter int ADDR_W = 32
) ();
    // Store request side
    logic              st_valid;
    logic              st_ready;
    logic [5:0]        st_op;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic              st_done;
    logic              st_err;

    // Data memory side
    logic              mem_en;
    logic [3:0]        mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output st_valid, st_op, st_addr, st_data, mem_rdata, mem_ack,
        input  st_ready, st_done, st_err, mem_en, mem_wen, mem_addr, mem_wdata
    );

    modport slave (
        input  st_valid, st_op, st_addr, st_data, mem_rdata, mem_ack,
        output st_ready, st_done, st_err, mem_en, mem_wen, mem_addr, mem_wdata
    );
endinterface

// File: rtl/store_data_unit.sv
// Formats sw/swl/swr/sb/sh data into little-endian byte lanes and drives the data-memory write port.
// Latency: accept at edge N, mem_en at N+1, st_done one cycle after the cycle mem_ack is seen (+1 read phase with STORE_RMW_EN).
// Backpressure: st_ready only in IDLE; mem_en/wen/addr/wdata held stable until mem_ack. STORE_RMW_EN selects read-modify-write.
module store_data_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    store_data_unit_if.slave  bus
);

    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SWL = 6'b101010;
    localparam logic [5:0] OP_SWR = 6'b101110;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
`ifdef STORE_RMW_EN
        S_READ  = 2'd1,
`endif
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        wen_q, wen_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;

    logic              lane_ok;
    logic [3:0]        lane_wen;
    logic [31:0]       lane_wdata;
    logic [1:0]        ea;
    logic [31:0]       d;

`ifndef STORE_RMW_EN
    // Read data only matters when partial stores are merged in the unit.
    logic unused_rdata;
    assign unused_rdata = ^bus.mem_rdata;
`endif

    // Lane formatting of the incoming request (only consumed on accept).
    always_comb begin
        lane_ok    = 1'b1;
        lane_wen   = 4'b0000;
        lane_wdata = 32'h0;
        ea         = bus.st_addr[1:0];
        d          = bus.st_data;
        case (bus.st_op)
            OP_SW: begin
                lane_wen   = 4'b1111;
                lane_wdata = d;
            end
            OP_SB: begin
                lane_wen   = 4'b0001 << ea;
                lane_wdata = {24'h0, d[7:0]} << {ea, 3'b000};
            end
            OP_SH: begin
                // ea[0] ignored, same as the load side.
                if (ea[1]) begin
                    lane_wen   = 4'b1100;
                    lane_wdata = {d[15:0], 16'h0};
                end else begin
                    lane_wen   = 4'b0011;
                    lane_wdata = {16'h0, d[15:0]};
                end
            end
            OP_SWL: begin
                case (ea)
                    2'b00:   begin lane_wen = 4'b0001; lane_wdata = {24'h0, d[31:24]}; end
                    2'b01:   begin lane_wen = 4'b0011; lane_wdata = {16'h0, d[31:16]}; end
                    2'b10:   begin lane_wen = 4'b0111; lane_wdata = {8'h0, d[31:8]};   end
                    default: begin lane_wen = 4'b1111; lane_wdata = d;                 end
                endcase
            end
            OP_SWR: begin
                case (ea)
                    2'b00:   begin lane_wen = 4'b1111; lane_wdata = d;                 end
                    2'b01:   begin lane_wen = 4'b1110; lane_wdata = {d[23:0], 8'h0};   end
                    2'b10:   begin lane_wen = 4'b1100; lane_wdata = {d[15:0], 16'h0};  end
                    default: begin lane_wen = 4'b1000; lane_wdata = {d[7:0], 24'h0};   end
                endcase
            end
            default: lane_ok = 1'b0;
        endcase
    end

    // Next-state and datapath update for the transaction FSM.
    always_comb begin
        state_d = state_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.st_valid) begin
                    addr_d = {bus.st_addr[ADDR_W-1:2], 2'b00};
                    if (!lane_ok) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        wen_d   = lane_wen;
                        wdata_d = lane_wdata;
                        state_d = S_WRITE;
`ifdef STORE_RMW_EN
                        // Partial word: fetch the old word first and merge.
                        if (lane_wen != 4'b1111) begin
                            state_d = S_READ;
                        end
`endif
                    end
                end
            end
`ifdef STORE_RMW_EN
            S_READ: begin
                if (bus.mem_ack) begin
                    for (int i = 0; i < 4; i++) begin
                        wdata_d[8*i +: 8] = wen_q[i] ? wdata_q[8*i +: 8] : bus.mem_rdata[8*i +: 8];
                    end
                    wen_d   = 4'b1111;
                    state_d = S_WRITE;
                end
            end
`endif
            S_WRITE: begin
                if (bus.mem_ack) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and transaction registers; reset drops any pending request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            wen_q   <= 4'b0000;
            wdata_q <= 32'h0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        bus.st_ready  = (state_q == S_IDLE);
        bus.st_done   = (state_q == S_DONE);
        bus.st_err    = (state_q == S_DONE) && err_q;
        bus.mem_en    = (state_q == S_WRITE)
`ifdef STORE_RMW_EN
                        || (state_q == S_READ)
`endif
                        ;
        bus.mem_wen   = (state_q == S_WRITE) ? wen_q : 4'b0000;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
    end

endmodule

// File: tb/tb_store_data_unit.sv
// Self-checking bench for store_data_unit: directed cases plus random stores.
// Expectations come from a byte-level reference model pushed to a scoreboard queue.
// A separate monitor compares memory requests and done/err pulses against the queue.
module tb_store_data_unit;

    localparam int AW = 32;

    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SWL = 6'b101010;
    localparam logic [5:0] OP_SWR = 6'b101110;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_LW  = 6'b100011;

    typedef struct {
        bit        err;
        bit [31:0] addr;
        bit [3:0]  wen;
        bit [31:0] wdata;
        bit        need_read;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    store_data_unit_if #(.ADDR_W(AW)) bus ();

    store_data_unit #(.ADDR_W(AW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          ack_dly = 0;
    logic [31:0] rd_word = 32'h0;
    int          done_cnt = 0;
    bit          rd_seen = 1'b0;
    bit          wr_seen = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, expv);
        end
    endtask

    // Reference: which bytes of rt land in which memory lane, byte by byte.
    function automatic exp_t model(input logic [5:0] op, input logic [31:0] addr,
                                   input logic [31:0] data, input logic [31:0] rd);
        exp_t     e;
        int       ea;
        bit [7:0] db[4];
        int       base;
        e.err = 1'b0; e.wen = 4'b0; e.wdata = 32'h0; e.need_read = 1'b0;
        e.addr = {addr[31:2], 2'b00};
        ea = int'(addr[1:0]);
        for (int i = 0; i < 4; i++) db[i] = data[8*i +: 8];
        case (op)
            OP_SW:  for (int i = 0; i < 4; i++) begin e.wen[i] = 1'b1; e.wdata[8*i +: 8] = db[i]; end
            OP_SB:  begin e.wen[ea] = 1'b1; e.wdata[8*ea +: 8] = db[0]; end
            OP_SH:  begin
                base = (ea >= 2) ? 2 : 0;
                e.wen[base] = 1'b1;   e.wdata[8*base +: 8] = db[0];
                e.wen[base+1] = 1'b1; e.wdata[8*(base+1) +: 8] = db[1];
            end
            OP_SWL: for (int i = 0; i <= ea; i++) begin e.wen[i] = 1'b1; e.wdata[8*i +: 8] = db[3-ea+i]; end
            OP_SWR: for (int i = ea; i < 4; i++) begin e.wen[i] = 1'b1; e.wdata[8*i +: 8] = db[i-ea]; end
            default: e.err = 1'b1;
        endcase
`ifdef STORE_RMW_EN
        if (!e.err && e.wen != 4'hF) begin
            e.need_read = 1'b1;
            for (int i = 0; i < 4; i++) if (!e.wen[i]) e.wdata[8*i +: 8] = rd[8*i +: 8];
            e.wen = 4'hF;
        end
`else
        if (rd == 32'h1) e.need_read = 1'b0;
`endif
        return e;
    endfunction

    // Issue one request; returns #1 after the accepting edge (or after the junk cycle).
    task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input int dly, input logic [31:0] rd, input bit junk);
        int guard = 0;
        @(negedge clk);
        while (!bus.st_ready && guard < 100) begin @(negedge clk); guard++; end
        chk("st_ready_wait", 32'(bus.st_ready), 32'd1);
        ack_dly = dly;
        rd_word = rd;
        bus.st_valid = 1'b1;
        bus.st_op = op;
        bus.st_addr = addr;
        bus.st_data = data;
        exp_q.push_back(model(op, addr, data, rd));
        @(posedge clk); #1;
        if (junk) begin
            bus.st_op = 6'($urandom);
            bus.st_addr = $urandom;
            bus.st_data = $urandom;
            @(posedge clk); #1;
        end
        bus.st_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while (!bus.st_ready && guard < 100) begin @(negedge clk); guard++; end
        chk("idle_wait", 32'(bus.st_ready), 32'd1);
    endtask

    // Memory responder: acks after ack_dly waiting cycles, stray acks while idle.
    initial begin
        int cnt = 0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            bus.mem_ack = 1'b0;
            bus.mem_rdata = rd_word;
            if (resetn && bus.mem_en) begin
                if (cnt >= ack_dly) begin bus.mem_ack = 1'b1; cnt = 0; end
                else cnt++;
            end else begin
                cnt = 0;
                if (resetn && $urandom_range(0, 3) == 0) bus.mem_ack = 1'b1;
            end
        end
    end

    // Monitor: compares every cycle the DUT presents a memory request or a done pulse.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (!resetn) begin
                rd_seen = 1'b0;
                wr_seen = 1'b0;
            end else begin
                if (bus.st_err && !bus.st_done) chk("st_err_without_done", 32'(bus.st_err), 32'd0);
                if (bus.mem_en) begin
                    if (exp_q.size() == 0) begin
                        chk("mem_en_unexpected", 32'(bus.mem_en), 32'd0);
                    end else begin
                        chk("mem_addr", bus.mem_addr, exp_q[0].addr);
                        if (bus.mem_wen == 4'b0000) begin
                            if (bus.mem_ack) rd_seen = 1'b1;
                        end else begin
                            chk("mem_wen", 32'(bus.mem_wen), 32'(exp_q[0].wen));
                            chk("mem_wdata", bus.mem_wdata, exp_q[0].wdata);
                            if (bus.mem_ack) wr_seen = 1'b1;
                        end
                    end
                end
                if (bus.st_done) begin
                    done_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("st_done_unexpected", 32'(bus.st_done), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("st_err", 32'(bus.st_err), 32'(e.err));
                        chk("write_seen", 32'(wr_seen), 32'(!e.err));
                        chk("read_seen", 32'(rd_seen), 32'(e.need_read));
                    end
                    rd_seen = 1'b0;
                    wr_seen = 1'b0;
                end
            end
        end
    end

    // Watchdog
    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    // Main stimulus
    initial begin
        int       d0;
        int       r;
        logic [5:0] op;
        bus.st_valid = 1'b0;
        bus.st_op = 6'h0;
        bus.st_addr = '0;
        bus.st_data = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_st_ready", 32'(bus.st_ready), 32'd1);
        chk("rst_st_done", 32'(bus.st_done), 32'd0);
        chk("rst_st_err", 32'(bus.st_err), 32'd0);
        chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst_mem_wen", 32'(bus.mem_wen), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        resetn = 1'b1;

        // sb to lane 3, ack in first cycle, latency check
        issue(OP_SB, 32'h0000_1003, 32'h0000_00AB, 0, 32'h0, 1'b0);
`ifndef STORE_RMW_EN
        chk("sb_mem_en_n1", 32'(bus.mem_en), 32'd1);
        @(posedge clk); #1;
        chk("sb_done_n2", 32'(bus.st_done), 32'd1);
`endif
        wait_idle();

        // swl / swr at offset 1
        issue(OP_SWL, 32'h0000_2001, 32'h1122_3344, 1, 32'h0F0F_F0F0, 1'b0);
        wait_idle();
        issue(OP_SWR, 32'h0000_2001, 32'h1122_3344, 0, 32'h0F0F_F0F0, 1'b0);
        wait_idle();

        // sh upper half, delayed ack, exactly one done pulse
        d0 = done_cnt;
        issue(OP_SH, 32'h0000_0006, 32'hCAFE_BEEF, 3, 32'h1234_5678, 1'b0);
        wait_idle();
        repeat (2) @(negedge clk);
        chk("sh_single_done", 32'(done_cnt - d0), 32'd1);

        // unsupported opcode: done+err next cycle, no memory access
        issue(OP_LW, 32'h0000_0040, 32'h0000_1234, 0, 32'h0, 1'b0);
        chk("lw_done_n1", 32'(bus.st_done), 32'd1);
        chk("lw_err_n1", 32'(bus.st_err), 32'd1);
        chk("lw_no_mem_en", 32'(bus.mem_en), 32'd0);
        wait_idle();

        // reset while waiting for the write ack
        issue(OP_SW, 32'h0000_5004, 32'hDEAD_BEEF, 20, 32'h0, 1'b0);
        d0 = done_cnt;
        #1 resetn = 1'b0;
        #1;
        chk("midrst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("midrst_st_ready", 32'(bus.st_ready), 32'd1);
        chk("midrst_st_done", 32'(bus.st_done), 32'd0);
        chk("midrst_mem_wen", 32'(bus.mem_wen), 32'd0);
        chk("midrst_mem_wdata", bus.mem_wdata, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("postrst_st_ready", 32'(bus.st_ready), 32'd1);
        chk("postrst_no_done", 32'(done_cnt - d0), 32'd0);
        issue(OP_SW, 32'h0000_5008, 32'h0BAD_F00D, 1, 32'h0, 1'b0);
        wait_idle();

`ifdef STORE_RMW_EN
        // read-modify-write merge of a byte store
        issue(OP_SB, 32'h0000_3001, 32'h0000_0055, 0, 32'hAABB_CCDD, 1'b0);
        wait_idle();
`endif

        // Random stores, random ack delays, busy-time st_valid noise
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0:       op = OP_SW;
                1, 7:    op = OP_SWL;
                2, 8:    op = OP_SWR;
                3, 4:    op = OP_SB;
                5, 6:    op = OP_SH;
                default: op = 6'($urandom);
            endcase
            issue(op, $urandom, $urandom, $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)));
        end
        wait_idle();
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_data_unit.md
Name: store_data_unit

Overview:
- Store-side counterpart of the load data aligner.
- Accepts one store request per transaction (sw/swl/swr/sb/sh), formats rt data into memory byte lanes with byte write-enables, and drives the data-memory write port through a req/ack handshake.
- Sits between the MEM-stage store decode and the data memory. Little-endian lane order: byte offset 0 maps to mem bits [7:0].

Parameters:
ADDR_W, 32, address width; mem_addr is word-aligned (low 2 bits forced 0)

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
st_valid  in  1  store request valid
st_ready  out  1  unit can accept a request (IDLE only)
st_op  in  6  opcode: 101011 sw, 101010 swl, 101110 swr, 101000 sb, 101001 sh
st_addr  in  ADDR_W  effective byte address
st_data  in  32  rt register value
st_done  out  1  one-cycle pulse: transaction finished
st_err  out  1  valid with st_done: unsupported opcode
mem_en  out  1  memory request, held until mem_ack
mem_wen  out  4  byte write enables; 0000 means read
mem_addr  out  ADDR_W  {st_addr[ADDR_W-1:2],2'b00}
mem_wdata  out  32  lane-aligned write data; disabled lanes driven 0
mem_rdata  in  32  read data (used only with RMW_EN)
mem_ack  in  1  memory completes current request this cycle

Behaviour:
- Reset (async, resetn=0): state IDLE, st_ready=1, st_done=0, st_err=0, mem_en=0, mem_wen=0, mem_addr=0, mem_wdata=0. Takes effect immediately, including mid-transaction. The pending request is dropped and no done pulse is issued.
- FSM states: IDLE, READ (RMW_EN only), WRITE, DONE.
- IDLE: st_ready=1. On st_valid&&st_ready, register op, addr and data, and compute lanes from ea=st_addr[1:0].
  - Valid opcode -> WRITE.
  - Unknown opcode -> DONE with st_err=1; no memory access.
- Lane rules (wen / wdata):
  - sw: 1111 / st_data.
  - sb: 1<<ea / st_data[7:0] placed in lane ea.
  - sh: ea[1]=0 -> 0011 / {16'b0,d[15:0]}. ea[1]=1 -> 1100 / {d[15:0],16'b0}. ea[0] is ignored, matching the load side.
  - swl, by ea:
    - 00 -> 0001 / {24'b0,d[31:24]}
    - 01 -> 0011 / {16'b0,d[31:16]}
    - 10 -> 0111 / {8'b0,d[31:8]}
    - 11 -> 1111 / d
  - swr, by ea:
    - 00 -> 1111 / d
    - 01 -> 1110 / {d[23:0],8'b0}
    - 10 -> 1100 / {d[15:0],16'b0}
    - 11 -> 1000 / {d[7:0],24'b0}
- WRITE: mem_en=1; mem_wen, mem_addr and mem_wdata are registered and stable until mem_ack. On mem_ack -> DONE; mem_en drops the next cycle.
- DONE: st_done=1 for exactly one cycle, then IDLE. st_ready is 0 in DONE, so the minimum spacing between requests is 3 cycles.
- Latency: accept at edge N, mem_en high at N+1. If ack arrives in cycle N+1, st_done is high in N+2.
- mem_ack is ignored outside READ/WRITE.
- st_valid changes while the unit is busy are ignored.

Optional Feature:
STORE_RMW_EN
- Defined: targets memories without byte strobes; every write uses mem_wen=1111.
  - Partial stores (wen != 1111) go IDLE -> READ. READ drives mem_en=1 and mem_wen=0000.
  - On mem_ack, mem_rdata is captured and merged per byte: lanes with computed wen=1 take the new data, other lanes keep the read data. Then -> WRITE with wen=1111.
  - Full-word stores (sw, swl ea=11, swr ea=00) skip READ.
- Undefined: no READ state, mem_rdata ignored, byte strobes driven as in the lane rules.

Test Plan:
- sb, addr=0x1003, data=0x000000AB, ack on 1st cycle -> mem_addr=0x1000, wen=1000, wdata=0xAB000000; st_done in cycle N+2.
- swl addr=0x2001, data=0x11223344 -> wen=0011, wdata=0x00001122. swr addr=0x2001 -> wen=1110, wdata=0x22334400.
- sh addr=0x0006, data=0xCAFEBEEF, mem_ack delayed 3 cycles -> wen=1100, wdata=0xBEEF0000 held stable all 3 cycles; one st_done pulse.
- st_op=100011 (lw) -> mem_en never asserted; st_done=1 and st_err=1 in cycle N+1.
- resetn low while in WRITE -> mem_en=0 immediately, no st_done; after release st_ready=1 and the next sw completes normally.
- STORE_RMW_EN: sb addr=0x3001, data=0x55, read returns 0xAABBCCDD -> READ with wen=0000, then WRITE with wen=1111, wdata=0xAABB55DD.
